// File: rtl/mac_vec_engine.sv
// mac_vec_engine: multi-lane signed multiply-add / dot-product engine.
// Two-stage pipeline (product register, then add/accumulate + shift +
// saturate into the output register), driven by an IDLE/RUN/DRAIN job FSM.
// Every pipeline register freezes while the output is stalled.
module mac_vec_engine #(
  parameter int N_LANES = 4,
  parameter int DW      = 16,
  parameter int ACC_W   = 40,
  parameter int LEN_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [5:0]              shift_i,
  input  logic [N_LANES*DW-1:0]   a_i_data,
  input  logic                    a_i_valid,
  output logic                    a_i_ready,
  input  logic [N_LANES*DW-1:0]   b_i_data,
  input  logic                    b_i_valid,
  output logic                    b_i_ready,
  input  logic [N_LANES*DW-1:0]   c_i_data,
  input  logic                    c_i_valid,
  output logic                    c_i_ready,
  output logic [N_LANES*DW-1:0]   d_o_data,
  output logic                    d_o_valid,
  input  logic                    d_o_ready,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LEN_W-1:0]        cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic               done_reg, done_next;
  logic               mode_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic [5:0]         shift_reg;
  logic               s1_valid_reg, s1_last_reg;
  logic               d_valid_reg;

  logic               srst;
  logic               stall;
  logic               beat;
  logic               last_beat;
  logic               s2_fire;
  logic               out_fire;
  logic               job_start;

  // Test mode has no functional effect.
  logic               unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Reset and soft clear are equivalent.
  assign srst      = ~rst_ni | clear_i;
  assign stall     = d_valid_reg & ~d_o_ready;
  assign job_start = (state_reg == IDLE) & start_i;
  // An input beat needs a and b, plus c in SIMPLE mode, and a free pipeline.
  assign beat      = (state_reg == RUN) & a_i_valid & b_i_valid
                     & (mode_reg | c_i_valid) & ~stall;
  assign last_beat = beat & ((cnt_reg + LEN_W'(1)) == len_reg);
  assign s2_fire   = s1_valid_reg & ~stall;
  // SIMPLE emits every beat; ACCUM emits only the final beat of the job.
  assign out_fire  = s2_fire & (~mode_reg | s1_last_reg);

  assign a_i_ready = beat;
  assign b_i_ready = beat;
  assign c_i_ready = beat & ~mode_reg;
  assign d_o_valid = d_valid_reg;
  assign busy_o    = (state_reg != IDLE);
  assign done_o    = done_reg;
  assign cnt_o     = cnt_reg;

  // FSM state and done pulse register.
  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; DRAIN ends on the last output handshake.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (last_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (d_valid_reg & d_o_ready & ~s1_valid_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Job parameters latched at start and the consumed-beat counter.
  always_ff @(posedge clk_i) begin
    if (srst) begin
      mode_reg  <= 1'b0;
      len_reg   <= '0;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (job_start) begin
      mode_reg  <= mode_i;
      len_reg   <= len_i;
      shift_reg <= shift_i;
      cnt_reg   <= '0;
    end else if (beat) begin
      cnt_reg   <= cnt_reg + LEN_W'(1);
    end
  end

  // Pipeline valid flags; all frozen during an output stall.
  always_ff @(posedge clk_i) begin
    if (srst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      d_valid_reg  <= 1'b0;
    end else if (~stall) begin
      s1_valid_reg <= beat;
      s1_last_reg  <= last_beat;
      d_valid_reg  <= out_fire;
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic signed [DW-1:0]      a_l, b_l, c_l;
    logic signed [2*DW-1:0]    p_reg;
    logic signed [DW-1:0]      c_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [ACC_W-1:0]   p_ext, c_ext, acc_sum, pre, shifted;
    logic                      ovf;
    logic [DW-1:0]             r;
    logic [DW-1:0]             d_reg;

    assign a_l = a_i_data[gi*DW +: DW];
    assign b_l = b_i_data[gi*DW +: DW];
    assign c_l = c_i_data[gi*DW +: DW];

    // Stage 1: signed product, with c carried alongside.
    always_ff @(posedge clk_i) begin
      if (srst) begin
        p_reg <= '0;
        c_reg <= '0;
      end else if (beat) begin
        p_reg <= a_l * b_l;
        c_reg <= c_l;
      end
    end

    assign p_ext   = ACC_W'(p_reg);
    assign c_ext   = ACC_W'(c_reg);
    assign acc_sum = acc_reg + p_ext;
    assign pre     = mode_reg ? acc_sum : (p_ext + c_ext);
    // Arithmetic shift sign-fills, so large shifts collapse to 0 or -1.
    assign shifted = pre >>> shift_reg;
    // Out of range when the bits above the DW-1 sign position disagree.
    assign ovf     = ~(&shifted[ACC_W-1:DW-1]) & (|shifted[ACC_W-1:DW-1]);
    assign r       = ovf ? (shifted[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}}
                                             : {1'b0, {(DW-1){1'b1}}})
                         : shifted[DW-1:0];

    // Accumulator: cleared at job start and after the final beat.
    always_ff @(posedge clk_i) begin
      if (srst) begin
        acc_reg <= '0;
      end else if (job_start) begin
        acc_reg <= '0;
      end else if (s2_fire & mode_reg) begin
        acc_reg <= s1_last_reg ? '0 : acc_sum;
      end
    end

    // Output register for this lane; held while stalled.
    always_ff @(posedge clk_i) begin
      if (srst) begin
        d_reg <= '0;
      end else if (out_fire) begin
        d_reg <= r;
      end
    end

    assign d_o_data[gi*DW +: DW] = d_reg;
  end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Testbench for mac_vec_engine: directed scenarios plus randomized jobs,
// all checked against an arithmetic reference model of the engine.
module tb_mac_vec_engine;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int W  = NL * DW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          test_mode_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [15:0]   len_i = '0;
  logic [5:0]    shift_i = '0;
  logic [W-1:0]  a_i_data = '0, b_i_data = '0, c_i_data = '0;
  logic          a_i_valid = 1'b0, b_i_valid = 1'b0, c_i_valid = 1'b0;
  logic          a_i_ready, b_i_ready, c_i_ready;
  logic [W-1:0]  d_o_data;
  logic          d_o_valid;
  logic          d_o_ready = 1'b0;
  logic          busy_o, done_o;
  logic [15:0]   cnt_o;

  mac_vec_engine dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .start_i(start_i), .mode_i(mode_i), .len_i(len_i), .shift_i(shift_i),
    .a_i_data(a_i_data), .a_i_valid(a_i_valid), .a_i_ready(a_i_ready),
    .b_i_data(b_i_data), .b_i_valid(b_i_valid), .b_i_ready(b_i_ready),
    .c_i_data(c_i_data), .c_i_valid(c_i_valid), .c_i_ready(c_i_ready),
    .d_o_data(d_o_data), .d_o_valid(d_o_valid), .d_o_ready(d_o_ready),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Job context and reference model state.
  bit           job_mode = 1'b0;
  int           job_len = 0;
  int           job_shift = 0;
  int           in_cnt = 0;
  int           out_cnt = 0;
  int           done_cnt = 0;
  longint       acc_m [NL];
  logic [W-1:0] exp_q [$];
  bit           mon_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Two's-complement wrap to 40 bits.
  function automatic longint wrap40(input longint v);
    return (v <<< 24) >>> 24;
  endfunction

  function automatic longint lane_of(input logic [W-1:0] v, input int k);
    logic signed [DW-1:0] e;
    e = v[k*DW +: DW];
    return longint'(e);
  endfunction

  function automatic longint model_simple(input longint a, input longint b,
                                          input longint c, input int sh);
    return sat16((a * b + c) >>> sh);
  endfunction

  function automatic longint model_accum(input longint acc, input int sh);
    return sat16(acc >>> sh);
  endfunction

  function automatic bit rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) begin
      case ($urandom_range(9))
        0: v[k*DW +: DW] = 16'h7FFF;
        1: v[k*DW +: DW] = 16'h8000;
        2: v[k*DW +: DW] = 16'hFFFF;
        3: v[k*DW +: DW] = 16'h0000;
        default: v[k*DW +: DW] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Compare process: records accepted beats into the model and checks
  // every output handshake, ready rules, stall stability and done.
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (a_i_ready | b_i_ready | c_i_ready) begin
        chk("rdy_ab_equal", b_i_ready, a_i_ready);
        chk("rdy_c_rule", c_i_ready, a_i_ready & ~job_mode);
        chk("rdy_needs_valid", a_i_valid & b_i_valid & (job_mode | c_i_valid), 1);
      end
      if (a_i_ready) begin
        in_cnt++;
        e = '0;
        if (!job_mode) begin
          for (int k = 0; k < NL; k++)
            e[k*DW +: DW] = 16'(model_simple(lane_of(a_i_data, k), lane_of(b_i_data, k),
                                             lane_of(c_i_data, k), job_shift));
          exp_q.push_back(e);
        end else begin
          for (int k = 0; k < NL; k++)
            acc_m[k] = wrap40(acc_m[k] + lane_of(a_i_data, k) * lane_of(b_i_data, k));
          if (in_cnt == job_len) begin
            for (int k = 0; k < NL; k++) begin
              e[k*DW +: DW] = 16'(model_accum(acc_m[k], job_shift));
              acc_m[k] = 0;
            end
            exp_q.push_back(e);
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid_held", d_o_valid, 1);
        chk("stall_data_held", d_o_data, prev_data);
      end
      if (d_o_valid & d_o_ready) begin
        out_cnt++;
        $display("d beat %0d: data %h", out_cnt, d_o_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_d_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("d_data", d_o_data, e);
        end
      end
      prev_stall = d_o_valid & ~d_o_ready;
      prev_data  = d_o_data;
      if (prev_stall && !job_mode)
        chk("inflight_le_2", (in_cnt - out_cnt) <= 2, 1);
      if (done_o) begin
        done_cnt++;
        chk("done_not_busy", busy_o, 0);
      end
    end
  end

  // Pulse start for one cycle; inputs are scrambled afterwards so that
  // only latched values can matter.
  task automatic start_job(input bit m, input int len, input int sh);
    @(posedge clk_i); #1;
    job_mode = m; job_len = len; job_shift = sh;
    in_cnt = 0; out_cnt = 0;
    for (int k = 0; k < NL; k++) acc_m[k] = 0;
    exp_q.delete();
    mode_i = m; len_i = 16'(len); shift_i = 6'(sh); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    mode_i = 1'($urandom); len_i = 16'($urandom); shift_i = 6'($urandom);
  endtask

  task automatic set_valids(input bit v);
    a_i_valid = v; b_i_valid = v; c_i_valid = v;
  endtask

  // One SIMPLE beat with exact cycle-by-cycle expectations.
  task automatic single_beat(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c,
                             input logic [W-1:0] expd);
    a_i_data = a; b_i_data = b; c_i_data = c;
    set_valids(1'b1);
    d_o_ready = 1'b1;
    start_job(1'b0, 1, 0);
    @(negedge clk_i);
    chk({tag, "_ready"}, a_i_ready & c_i_ready, 1);
    chk({tag, "_busy"}, busy_o, 1);
    @(posedge clk_i); #1;
    set_valids(1'b0);
    @(negedge clk_i);
    chk({tag, "_dvalid_c1"}, d_o_valid, 0);
    chk({tag, "_cnt"}, cnt_o, 1);
    @(negedge clk_i);
    chk({tag, "_dvalid_c2"}, d_o_valid, 1);
    chk({tag, "_data_literal"}, d_o_data, expd);
    chk({tag, "_done_early"}, done_o, 0);
    @(negedge clk_i);
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_dvalid_after"}, d_o_valid, 0);
    @(negedge clk_i);
    chk({tag, "_done_one_pulse"}, done_o, 0);
    chk({tag, "_cnt_hold"}, cnt_o, 1);
  endtask

  // Randomized job with protocol-correct producers and a random consumer.
  task automatic run_job(input bit m, input int len, input int sh, input int vprob,
                         input int rprob, input bit bp, input bit restart);
    logic [W-1:0] va [$], vb [$], vc [$];
    int  idx, cyc, done0;
    bit  took;
    for (int i = 0; i < len; i++) begin
      va.push_back(rand_vec()); vb.push_back(rand_vec()); vc.push_back(rand_vec());
    end
    idx = 0; cyc = 0; done0 = done_cnt;
    a_i_data = va[0]; b_i_data = vb[0]; c_i_data = vc[0];
    a_i_valid = rnd(vprob); b_i_valid = rnd(vprob); c_i_valid = rnd(vprob);
    d_o_ready = bp ? 1'b1 : rnd(rprob);
    start_job(m, len, sh);
    while (done_cnt == done0 && cyc < 2000) begin
      @(negedge clk_i);
      took = a_i_ready;
      @(posedge clk_i); #1;
      if (restart && cyc == 2) begin
        start_i = 1'b1; mode_i = ~m; len_i = 16'd2; shift_i = 6'd5;
      end
      if (restart && cyc == 3) start_i = 1'b0;
      if (took) idx++;
      if (idx < len) begin
        if (took || !a_i_valid) begin a_i_data = va[idx]; a_i_valid = rnd(vprob); end
        if (took || !b_i_valid) begin b_i_data = vb[idx]; b_i_valid = rnd(vprob); end
        if (took || !c_i_valid) begin c_i_data = vc[idx]; c_i_valid = rnd(vprob); end
      end else begin
        set_valids(1'b0);
      end
      d_o_ready = bp ? !(cyc >= 4 && cyc < 9) : rnd(rprob);
      cyc++;
    end
    set_valids(1'b0);
    chk("job_done_seen", done_cnt - done0, 1);
    chk("job_cnt_final", cnt_o, len);
    chk("job_idle", busy_o, 0);
    chk("job_queue_empty", exp_q.size(), 0);
    chk("job_out_count", out_cnt, m ? 1 : len);
    $display("job mode=%0d len=%0d shift=%0d cycles=%0d", m, len, sh, cyc);
  endtask

  // Abort a running SIMPLE job with an output stalled, via reset or clear.
  task automatic abort_job(input bit use_clear);
    a_i_data = rand_vec(); b_i_data = rand_vec(); c_i_data = rand_vec();
    set_valids(1'b1);
    d_o_ready = 1'b0;
    start_job(1'b0, 8, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("abort_pre_dvalid", d_o_valid, 1);
    chk("abort_pre_busy", busy_o, 1);
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    if (use_clear) clear_i = 1'b1; else rst_ni = 1'b0;
    @(posedge clk_i); #1;
    clear_i = 1'b0; rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_dvalid", d_o_valid, 0);
    chk("abort_ddata", d_o_data, 0);
    chk("abort_cnt", cnt_o, 0);
    chk("abort_ready", a_i_ready | b_i_ready | c_i_ready, 0);
    @(posedge clk_i); #1;
    set_valids(1'b0);
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    int sh;
    // Model pins against hand-computed values.
    chk("pin_simple", model_simple(3, -4, 10, 0), -2);
    chk("pin_sat_hi", model_simple(32767, 32767, 0, 0), 32767);
    chk("pin_sat_lo", model_simple(-32768, 32767, -1, 0), -32768);
    chk("pin_accum", model_accum(4000000, 8), 15625);
    chk("pin_bigshift", model_simple(-5, 3, 0, 40), -1);
    chk("pin_wrap40", wrap40(longint'(1) <<< 39), -(longint'(1) <<< 39));

    // Reset state, with inputs offered to show they are refused.
    set_valids(1'b1);
    d_o_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_dvalid", d_o_valid, 0);
    chk("rst_ddata", d_o_data, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_ready", a_i_ready | b_i_ready | c_i_ready, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    set_valids(1'b0);
    mon_en = 1'b1;

    // SIMPLE single beat, all lanes 3*-4+10 = -2.
    single_beat("t1", {4{16'h0003}}, {4{16'hFFFC}}, {4{16'h000A}}, 64'hFFFE_FFFE_FFFE_FFFE);
    // Saturation and independent lanes: -2, +sat, -sat, 100*-7+5 = -695.
    single_beat("t3", {16'h0064, 16'h8000, 16'h7FFF, 16'h0003},
                {16'hFFF9, 16'h7FFF, 16'h7FFF, 16'hFFFC},
                {16'h0005, 16'hFFFF, 16'h0000, 16'h000A}, 64'hFD49_8000_7FFF_FFFE);

    // ACCUM len=4, 1000*1000 summed four times, >>> 8.
    begin
      int nbeat, ndv, ndone, last_rdy, dv_at;
      nbeat = 0; ndv = 0; ndone = 0; last_rdy = -1; dv_at = -1;
      a_i_data = {4{16'd1000}}; b_i_data = {4{16'd1000}}; c_i_data = {4{16'd7}};
      set_valids(1'b1);
      d_o_ready = 1'b1;
      start_job(1'b1, 4, 8);
      for (int i = 0; i < 15; i++) begin
        @(negedge clk_i);
        if (a_i_ready) begin nbeat++; last_rdy = i; end
        if (d_o_valid) begin
          ndv++; dv_at = i;
          chk("t2_data_literal", d_o_data, 64'h3D09_3D09_3D09_3D09);
        end
        if (done_o) begin
          ndone++;
          chk("t2_busy_at_done", busy_o, 0);
        end
      end
      set_valids(1'b0);
      chk("t2_beats", nbeat, 4);
      chk("t2_outputs", ndv, 1);
      chk("t2_latency", dv_at - last_rdy, 2);
      chk("t2_done_pulses", ndone, 1);
      chk("t2_cnt", cnt_o, 4);
    end

    // len=0: done next cycle, nothing consumed or produced.
    set_valids(1'b1);
    start_job(1'b0, 0, 0);
    @(negedge clk_i);
    chk("len0_done", done_o, 1);
    chk("len0_busy", busy_o, 0);
    chk("len0_ready", a_i_ready | b_i_ready | c_i_ready, 0);
    chk("len0_dvalid", d_o_valid, 0);
    @(negedge clk_i);
    chk("len0_done_pulse", done_o, 0);
    chk("len0_dvalid2", d_o_valid, 0);
    @(posedge clk_i); #1;
    set_valids(1'b0);

    // Backpressure: output held off for five cycles mid-job.
    run_job(1'b0, 8, 3, 100, 100, 1'b1, 1'b0);
    // Start pulsed during RUN must be ignored.
    run_job(1'b0, 8, 2, 100, 100, 1'b0, 1'b1);
    run_job(1'b1, 8, 6, 100, 100, 1'b0, 1'b1);

    // Mid-job aborts, each followed by a fresh ACCUM job.
    abort_job(1'b0);
    run_job(1'b1, 6, 4, 100, 100, 1'b0, 1'b0);
    abort_job(1'b1);
    run_job(1'b1, 5, 0, 80, 70, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 14; j++) begin
      sh = ($urandom_range(9) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 18);
      run_job(1'($urandom_range(1)), $urandom_range(1, 20), sh,
              $urandom_range(40, 100), $urandom_range(30, 100), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
